step_counter: RTL and testbench
===============================

STEP_COUNTER -- requirements
Module: step_counter

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the counter, step, limit, threshold and load width in bits (legal 2..32).
REQ-002 clk  input  1  SHALL be the clock; all state updates on the rising edge.
REQ-003 reset  input  1  SHALL be the reset: synchronous, active-high.
REQ-004 en  input  1  SHALL advance the counter one step per cycle when high.
REQ-005 step  input  WIDTH  SHALL be the increment added per enabled cycle.
REQ-006 limit  input  WIDTH  SHALL be the terminal count value.
REQ-007 thresh  input  WIDTH  SHALL be the flag threshold.
REQ-008 mode  input  2  SHALL select the terminal behaviour: 00 WRAP, 01 SATURATE, 10 ONESHOT, 11 reserved, treated as WRAP.
REQ-009 load  input  1  SHALL request a synchronous load of load_val.
REQ-010 load_val  input  WIDTH  SHALL be the value to load.
REQ-011 count  output  WIDTH  SHALL be the registered count.
REQ-012 flag  output  1  SHALL be the registered threshold flag.
REQ-013 term  output  1  SHALL be a registered one-cycle terminal pulse.
REQ-014 busy  output  1  SHALL be high when the FSM is in RUN.

Function
REQ-015 FSM SHALL have states RUN and HOLD; only RUN advances count.
REQ-016 Per-cycle priority SHALL be reset > load > en; with no load and en low (or HOLD), count and flag hold and term is 0.
REQ-017 load SHALL set count to min(load_val, limit), clear flag and term, and enter RUN, regardless of state or en.
REQ-018 In RUN with en high and count != limit, sum SHALL be count+step computed in WIDTH+1 bits; count <= limit if sum > limit, else sum (overflow clamps, never wraps silently).
REQ-019 In the same case, flag SHALL be set to 1 if count >= thresh (pre-increment value), else hold.
REQ-020 In RUN with en high and count == limit (terminal), term SHALL be 1 for that next cycle.
REQ-021 Terminal in WRAP: count <= 0, flag <= 0, stay RUN.
REQ-022 Terminal in SATURATE: count holds at limit, flag holds, enter HOLD.
REQ-023 Terminal in ONESHOT: count <= 0, flag <= 0, enter HOLD.
REQ-024 HOLD SHALL be left only by load or reset; term SHALL NOT repeat while in HOLD.
REQ-025 step == 0 SHALL hold count; term fires only if count == limit.
REQ-026 limit == 0 SHALL make every enabled RUN cycle terminal.
REQ-027 mode, step, limit, thresh SHALL be sampled live each cycle; changes act on the next edge.
REQ-028 If limit is lowered below the current count, the next enabled cycle SHALL clamp count to the new limit without term.

Reset
REQ-029 reset SHALL set count=0, flag=0, term=0, state RUN (busy=1) on the next edge, overriding load and en, including mid-sequence and from HOLD.
REQ-030 The counter SHALL resume counting from 0 on the first enabled cycle after reset deasserts.

Structure
REQ-031 Package step_counter_pkg SHALL hold the mode encoding constants (MODE_WRAP, MODE_SAT, MODE_ONESHOT) and the state enum (ST_RUN, ST_HOLD).
REQ-032 The add/clamp/terminal-detect datapath SHALL be a combinational sub-module step_counter_next (inputs count, step, limit; outputs next value, at_limit).
REQ-033 All outputs SHALL be registered; no combinational path from input to output.

Verification (WIDTH=4 unless stated; en=1)
REQ-034 WRAP, step=3, limit=15, thresh=9: count 0,3,6,9,12,15,0; flag high while count is 12 and 15; term high exactly with the return to 0.
REQ-035 WRAP, step=4, limit=10: count 0,4,8,10,0; term one pulse per period; WIDTH=8, step=200, limit=255: 0,200,255,0.
REQ-036 SATURATE, step=5, limit=15: 0,5,10,15, then hold 15, busy=0, one term pulse; load=1 load_val=3 -> count 3, flag 0, busy 1.
REQ-037 ONESHOT, step=3, limit=15: reaches 15 then 0, busy=0, count stays 0 with en high; load_val=20 at WIDTH=8, limit=15 -> count 15.
REQ-038 Reset asserted at count=9 and simultaneously with load -> count 0, flag 0, term 0, busy 1; load plus en together -> load wins.
REQ-039 Edge cases: step=0 -> count frozen, no term; limit=0 -> term every cycle, count 0; limit lowered from 15 to 4 at count 9 -> count 4 next, no term.

Source files
------------

// File: rtl/step_counter_pkg.sv
// rtl/step_counter_pkg.sv - mode encodings and FSM state type for step_counter
package step_counter_pkg;

   localparam logic [1:0] MODE_WRAP    = 2'b00;
   localparam logic [1:0] MODE_SAT     = 2'b01;
   localparam logic [1:0] MODE_ONESHOT = 2'b10;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

endpackage

// File: rtl/step_counter_next.sv
// rtl/step_counter_next.sv - add/clamp and terminal detect for step_counter
module step_counter_next #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] count,
   input  logic [WIDTH-1:0] step,
   input  logic [WIDTH-1:0] limit,
   output logic [WIDTH-1:0] next_val,
   output logic             at_limit
);

   logic [WIDTH:0] sum;

   // One extra bit so a carry out is caught and clamped instead of wrapping.
   always_comb begin
      sum = {1'b0, count} + {1'b0, step};
      if (sum > {1'b0, limit})
         next_val = limit;
      else
         next_val = sum[WIDTH-1:0];
   end

   assign at_limit = (count == limit);

endmodule

// File: rtl/step_counter.sv
// rtl/step_counter.sv - stepped up-counter with wrap/saturate/oneshot terminal modes
module step_counter
   import step_counter_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [WIDTH-1:0] step,
   input  logic [WIDTH-1:0] limit,
   input  logic [WIDTH-1:0] thresh,
   input  logic [1:0]       mode,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             flag,
   output logic             term,
   output logic             busy
);

   state_t           state;
   logic [WIDTH-1:0] next_val;
   logic             at_limit;

   step_counter_next #(.WIDTH(WIDTH)) u_next (
      .count    (count),
      .step     (step),
      .limit    (limit),
      .next_val (next_val),
      .at_limit (at_limit)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
         flag  <= 1'b0;
         term  <= 1'b0;
         state <= ST_RUN;
      end else if (load) begin
         count <= (load_val > limit) ? limit : load_val;
         flag  <= 1'b0;
         term  <= 1'b0;
         state <= ST_RUN;
      end else if (state == ST_RUN && en) begin
         if (at_limit) begin
            term <= 1'b1;
            case (mode)
               MODE_SAT: state <= ST_HOLD;
               MODE_ONESHOT: begin
                  count <= '0;
                  flag  <= 1'b0;
                  state <= ST_HOLD;
               end
               default: begin
                  count <= '0;
                  flag  <= 1'b0;
               end
            endcase
         end else begin
            // Threshold compares the value before this step is applied.
            if (count >= thresh)
               flag <= 1'b1;
            count <= next_val;
            term  <= 1'b0;
         end
      end else begin
         term <= 1'b0;
      end
   end

   assign busy = (state == ST_RUN);

endmodule

// File: tb/tb_step_counter.sv
// tb/tb_step_counter.sv - vector table, hand sequences and random model check for step_counter
module tb_step_counter;

   typedef struct {
      bit       rst, ld, en;
      bit [1:0] mode;
      bit [3:0] step, lim, th, lv;
      int       ec;
      bit       ef, et, eb;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset, en, load;
   logic [1:0] mode;
   logic [3:0] step, limit, thresh, load_val;
   logic [3:0] count;
   logic       flag, term, busy;

   logic       reset8, en8, load8;
   logic [1:0] mode8;
   logic [7:0] step8, limit8, thresh8, load_val8;
   logic [7:0] count8;
   logic       flag8, term8, busy8;

   int total = 0;
   int bad   = 0;
   vec_t vecs[$];

   always #5 clk = ~clk;

   step_counter #(.WIDTH(4)) dut4 (
      .clk(clk), .reset(reset), .en(en), .step(step), .limit(limit),
      .thresh(thresh), .mode(mode), .load(load), .load_val(load_val),
      .count(count), .flag(flag), .term(term), .busy(busy)
   );

   step_counter #(.WIDTH(8)) dut8 (
      .clk(clk), .reset(reset8), .en(en8), .step(step8), .limit(limit8),
      .thresh(thresh8), .mode(mode8), .load(load8), .load_val(load_val8),
      .count(count8), .flag(flag8), .term(term8), .busy(busy8)
   );

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic add(input bit r, input bit l, input bit e, input bit [1:0] m,
                      input bit [3:0] s, input bit [3:0] lm, input bit [3:0] t,
                      input bit [3:0] v, input int c, input bit f, input bit tm,
                      input bit b);
      vec_t x;
      x.rst = r; x.ld = l; x.en = e; x.mode = m; x.step = s; x.lim = lm;
      x.th = t; x.lv = v; x.ec = c; x.ef = f; x.et = tm; x.eb = b;
      vecs.push_back(x);
   endtask

   task automatic step8_chk(input string name, input bit r, input bit l, input bit e,
                            input bit [1:0] m, input int s, input int lm, input int v,
                            input int c, input bit tm, input bit b);
      @(negedge clk);
      reset8 = r; load8 = l; en8 = e; mode8 = m;
      step8 = s[7:0]; limit8 = lm[7:0]; load_val8 = v[7:0]; thresh8 = 8'hff;
      @(posedge clk); #1;
      chk({name, ".count"}, count8, c);
      chk({name, ".term"}, term8, tm);
      chk({name, ".busy"}, busy8, b);
   endtask

   // Reference model state, plain integers.
   int  mc, mf, mt, mrun;

   task automatic model_step(input bit r, input bit l, input bit e, input int m,
                             input int s, input int lm, input int t, input int v);
      if (r) begin
         mc = 0; mf = 0; mt = 0; mrun = 1;
      end else if (l) begin
         mc = (v < lm) ? v : lm; mf = 0; mt = 0; mrun = 1;
      end else if (mrun == 1 && e) begin
         if (mc == lm) begin
            mt = 1;
            if (m == 1) mrun = 0;
            else if (m == 2) begin mc = 0; mf = 0; mrun = 0; end
            else begin mc = 0; mf = 0; end
         end else begin
            if (mc >= t) mf = 1;
            mc = (mc + s > lm) ? lm : mc + s;
            mt = 0;
         end
      end else begin
         mt = 0;
      end
   endtask

   initial begin
      reset = 1; en = 0; load = 0; mode = 0; step = 0; limit = 0; thresh = 0; load_val = 0;
      reset8 = 1; en8 = 0; load8 = 0; mode8 = 0; step8 = 0; limit8 = 0; thresh8 = 0; load_val8 = 0;

      // wrap, step 3, limit 15, thresh 9
      add(1,0,0,0,3,15,9,0, 0,0,0,1);
      add(0,0,1,0,3,15,9,0, 3,0,0,1);
      add(0,0,1,0,3,15,9,0, 6,0,0,1);
      add(0,0,1,0,3,15,9,0, 9,0,0,1);
      add(0,0,1,0,3,15,9,0, 12,1,0,1);
      add(0,0,1,0,3,15,9,0, 15,1,0,1);
      add(0,0,1,0,3,15,9,0, 0,0,1,1);
      add(0,0,1,0,3,15,9,0, 3,0,0,1);
      // wrap, step 4, limit 10
      add(1,0,0,0,4,10,15,0, 0,0,0,1);
      add(0,0,1,0,4,10,15,0, 4,0,0,1);
      add(0,0,1,0,4,10,15,0, 8,0,0,1);
      add(0,0,1,0,4,10,15,0, 10,0,0,1);
      add(0,0,1,0,4,10,15,0, 0,0,1,1);
      add(0,0,1,0,4,10,15,0, 4,0,0,1);
      add(0,0,1,0,4,10,15,0, 8,0,0,1);
      add(0,0,1,0,4,10,15,0, 10,0,0,1);
      add(0,0,1,0,4,10,15,0, 0,0,1,1);
      // saturate, step 5, limit 15, thresh 5, then load 3
      add(1,0,0,1,5,15,5,0, 0,0,0,1);
      add(0,0,1,1,5,15,5,0, 5,0,0,1);
      add(0,0,1,1,5,15,5,0, 10,1,0,1);
      add(0,0,1,1,5,15,5,0, 15,1,0,1);
      add(0,0,1,1,5,15,5,0, 15,1,1,0);
      add(0,0,1,1,5,15,5,0, 15,1,0,0);
      add(0,0,1,1,5,15,5,0, 15,1,0,0);
      add(0,1,1,1,5,15,5,3, 3,0,0,1);
      // oneshot, step 3, limit 15; reset from hold; resume from 0
      add(1,0,0,2,3,15,15,0, 0,0,0,1);
      add(0,0,1,2,3,15,15,0, 3,0,0,1);
      add(0,0,1,2,3,15,15,0, 6,0,0,1);
      add(0,0,1,2,3,15,15,0, 9,0,0,1);
      add(0,0,1,2,3,15,15,0, 12,0,0,1);
      add(0,0,1,2,3,15,15,0, 15,0,0,1);
      add(0,0,1,2,3,15,15,0, 0,0,1,0);
      add(0,0,1,2,3,15,15,0, 0,0,0,0);
      add(0,0,1,2,3,15,15,0, 0,0,0,0);
      add(1,0,1,2,3,15,15,0, 0,0,0,1);
      add(0,0,1,2,3,15,15,0, 3,0,0,1);
      // reset mid-count with load, then load vs en, thresh 6
      add(1,0,0,0,3,15,6,0, 0,0,0,1);
      add(0,0,1,0,3,15,6,0, 3,0,0,1);
      add(0,0,1,0,3,15,6,0, 6,0,0,1);
      add(0,0,1,0,3,15,6,0, 9,1,0,1);
      add(1,1,1,0,3,15,6,5, 0,0,0,1);
      add(0,1,1,0,3,15,6,5, 5,0,0,1);
      add(0,0,1,0,3,15,6,0, 8,0,0,1);
      add(0,0,1,0,3,15,6,0, 11,1,0,1);
      // load above limit clamps; en low holds; then terminal
      add(0,1,0,0,3,10,6,12, 10,0,0,1);
      add(0,0,0,0,3,10,6,0, 10,0,0,1);
      add(0,0,1,0,3,10,6,0, 0,0,1,1);
      // step 0 freezes; limit 0 terminal every cycle
      add(1,0,0,0,0,15,15,0, 0,0,0,1);
      add(0,0,1,0,0,15,15,0, 0,0,0,1);
      add(0,0,1,0,0,15,15,0, 0,0,0,1);
      add(0,0,1,0,0,15,15,0, 0,0,0,1);
      add(0,0,1,0,3,0,15,0, 0,0,1,1);
      add(0,0,1,0,3,0,15,0, 0,0,1,1);
      add(0,0,1,0,3,0,15,0, 0,0,1,1);
      // limit lowered below count clamps without term
      add(1,0,0,0,3,15,15,0, 0,0,0,1);
      add(0,0,1,0,3,15,15,0, 3,0,0,1);
      add(0,0,1,0,3,15,15,0, 6,0,0,1);
      add(0,0,0,0,3,15,15,0, 6,0,0,1);
      add(0,0,1,0,3,15,15,0, 9,0,0,1);
      add(0,0,1,0,3,4,15,0, 4,0,0,1);
      add(0,0,1,0,3,4,15,0, 0,0,1,1);

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         reset = vecs[i].rst; load = vecs[i].ld; en = vecs[i].en; mode = vecs[i].mode;
         step = vecs[i].step; limit = vecs[i].lim; thresh = vecs[i].th; load_val = vecs[i].lv;
         @(posedge clk); #1;
         chk($sformatf("vec%0d.count", i), count, vecs[i].ec);
         chk($sformatf("vec%0d.flag", i), flag, vecs[i].ef);
         chk($sformatf("vec%0d.term", i), term, vecs[i].et);
         chk($sformatf("vec%0d.busy", i), busy, vecs[i].eb);
      end

      // 8-bit instance: clamp on carry-out, load above limit, oneshot stop
      step8_chk("w8_reset", 1,0,0,0, 200,255,0, 0,0,1);
      step8_chk("w8_s1",    0,0,1,0, 200,255,0, 200,0,1);
      step8_chk("w8_s2",    0,0,1,0, 200,255,0, 255,0,1);
      step8_chk("w8_s3",    0,0,1,0, 200,255,0, 0,1,1);
      step8_chk("w8_load",  0,1,1,2, 3,15,20, 15,0,1);
      step8_chk("w8_one",   0,0,1,2, 3,15,0, 0,1,0);
      step8_chk("w8_hold",  0,0,1,2, 3,15,0, 0,0,0);

      // Randomised run against the reference model.
      begin
         int rm, rs, rl, rt;
         bit rr, rld, re;
         int rv;
         rm = 0; rs = 3; rl = 15; rt = 9;
         model_step(1, 0, 0, rm, rs, rl, rt, 0);
         @(negedge clk);
         reset = 1; load = 0; en = 0;
         @(posedge clk); #1;
         for (int n = 0; n < 800; n++) begin
            if ($urandom_range(15) == 0) rm = $urandom_range(3);
            if ($urandom_range(15) == 0) rs = $urandom_range(15);
            if ($urandom_range(15) == 0) rl = $urandom_range(15);
            if ($urandom_range(15) == 0) rt = $urandom_range(15);
            rr  = ($urandom_range(49) == 0);
            rld = ($urandom_range(11) == 0);
            re  = ($urandom_range(3) != 0);
            rv  = $urandom_range(15);
            model_step(rr, rld, re, rm, rs, rl, rt, rv);
            @(negedge clk);
            reset = rr; load = rld; en = re; mode = rm[1:0];
            step = rs[3:0]; limit = rl[3:0]; thresh = rt[3:0]; load_val = rv[3:0];
            @(posedge clk); #1;
            chk($sformatf("rnd%0d.count", n), count, mc);
            chk($sformatf("rnd%0d.flag", n), flag, mf);
            chk($sformatf("rnd%0d.term", n), term, mt);
            chk($sformatf("rnd%0d.busy", n), busy, mrun);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
